// File: rtl/fetch_queue_pkg.sv
// Shared constants for the instruction prefetch queue: default widths and the
// instruction presented to decode when nothing is buffered.
package fetch_queue_pkg;

    localparam int FQ_ADDR_WIDTH  = 32;
    localparam int FQ_INSTR_WIDTH = 32;
    localparam int FQ_WORD_BYTES  = 4;

    // addi x0, x0, 0
    localparam logic [31:0] FQ_NOP_INSTR = 32'h0000_0013;

    // Entry counters hold 0..depth inclusive.
    function automatic int fq_cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fetch_queue_fifo.sv
// Synchronous circular FIFO with push/pop/clear and an occupancy count.
// Head data is read straight from storage, so it is available as soon as count>0.
module fq_fifo
    import fetch_queue_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push_i,
    input  logic [WIDTH-1:0]             data_i,
    input  logic                         pop_i,
    input  logic                         clear_i,
    output logic [WIDTH-1:0]             data_o,
    output logic [fq_cnt_w(DEPTH)-1:0]   count_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = fq_cnt_w(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             empty, full, do_push, do_pop;

    assign empty   = (cnt_q == '0);
    assign full    = (cnt_q == CW'(DEPTH));
    assign do_pop  = pop_i && !empty;
    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign do_push = push_i && (!full || do_pop);

    always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (clear_i) begin
            wr_d  = '0;
            rd_d  = '0;
            cnt_d = '0;
        end else begin
            if (do_push) wr_d = wr_q + PW'(1);
            if (do_pop)  rd_d = rd_q + PW'(1);
            case ({do_push, do_pop})
                2'b10:   cnt_d = cnt_q + CW'(1);
                2'b01:   cnt_d = cnt_q - CW'(1);
                default: cnt_d = cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !clear_i) mem_q[wr_q] <= data_i;
    end

    assign data_o  = mem_q[rd_q];
    assign count_o = cnt_q;

endmodule

// File: rtl/fetch_queue.sv
// Instruction prefetch queue: credit-limited sequential fetch, in-order response
// buffering with PCs, and redirect handling that discards stale in-flight data.
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int                    DEPTH       = 4,
    parameter int                    ADDR_WIDTH  = FQ_ADDR_WIDTH,
    parameter int                    INSTR_WIDTH = FQ_INSTR_WIDTH,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   Redirect_Valid,
    input  logic [ADDR_WIDTH-1:0]  Redirect_PC,
    input  logic                   Stall,
    output logic                   Imem_ReqValid,
    input  logic                   Imem_ReqReady,
    output logic [ADDR_WIDTH-1:0]  Imem_ReqAddr,
    input  logic                   Imem_RspValid,
    input  logic [INSTR_WIDTH-1:0] Imem_RspInstr,
    output logic                   FQ_Valid,
    output logic [ADDR_WIDTH-1:0]  FQ_PC,
    output logic [INSTR_WIDTH-1:0] FQ_Instr
);

    localparam int CW = fq_cnt_w(DEPTH);
    localparam int EW = ADDR_WIDTH + INSTR_WIDTH;

    logic [ADDR_WIDTH-1:0] fpc_q, fpc_d, rsp_pc_q, rsp_pc_d;
    logic [CW-1:0]         outst_q, outst_d, drop_q, drop_d, count;
    logic [CW:0]           inflight;
    logic                  credit_ok, req_fire, rsp_ret, rsp_keep, rsp_drop;
    logic                  push, pop, head_vld;
    logic [EW-1:0]         head;

    // Buffered plus outstanding never exceeds DEPTH, so every response has a slot.
    assign inflight  = {1'b0, count} + {1'b0, outst_q};
    assign credit_ok = inflight < (CW+1)'(DEPTH);

    assign Imem_ReqValid = rst_n && !Redirect_Valid && credit_ok;
    assign Imem_ReqAddr  = {fpc_q[ADDR_WIDTH-1:2], 2'b00};
    assign req_fire      = Imem_ReqValid && Imem_ReqReady;

    assign rsp_ret  = Imem_RspValid && (outst_q != '0);
    assign rsp_drop = rsp_ret && (drop_q != '0);
    assign rsp_keep = rsp_ret && (drop_q == '0) && !Redirect_Valid;

    assign head_vld = (count != '0);
    assign push     = rsp_keep;
    assign pop      = head_vld && !Stall && !Redirect_Valid;

    always_comb begin
        fpc_d    = fpc_q;
        rsp_pc_d = rsp_pc_q;
        outst_d  = outst_q;
        drop_d   = drop_q;
        if (Redirect_Valid) begin
            fpc_d    = Redirect_PC;
            rsp_pc_d = Redirect_PC;
            outst_d  = outst_q - CW'(rsp_ret);
            // Everything still in flight is stale; outst already includes
            // earlier drops, so it alone is the new drop count.
            drop_d   = outst_d;
        end else begin
            if (req_fire) fpc_d    = fpc_q + ADDR_WIDTH'(FQ_WORD_BYTES);
            if (rsp_keep) rsp_pc_d = rsp_pc_q + ADDR_WIDTH'(FQ_WORD_BYTES);
            if (rsp_drop) drop_d   = drop_q - CW'(1);
            outst_d = outst_q + CW'(req_fire) - CW'(rsp_ret);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fpc_q    <= RESET_PC;
            rsp_pc_q <= RESET_PC;
            outst_q  <= '0;
            drop_q   <= '0;
        end else begin
            fpc_q    <= fpc_d;
            rsp_pc_q <= rsp_pc_d;
            outst_q  <= outst_d;
            drop_q   <= drop_d;
        end
    end

    fq_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .data_i  ({rsp_pc_q, Imem_RspInstr}),
        .pop_i   (pop),
        .clear_i (Redirect_Valid),
        .data_o  (head),
        .count_o (count)
    );

    assign FQ_Valid = head_vld;
    assign FQ_PC    = head_vld ? head[EW-1:INSTR_WIDTH] : rsp_pc_q;
    assign FQ_Instr = head_vld ? head[INSTR_WIDTH-1:0] : INSTR_WIDTH'(FQ_NOP_INSTR);

endmodule
